store_align_unit: RTL

Parametrised store-path aligner between the pipeline's memory stage and the data-memory write port. It accepts one store per handshake (address, data, funct3) and produces byte-lane write masks and lane-aligned write data for an XLEN-wide bus. It registers the result behind a valid/ready interface. Optionally, it splits stores that cross a bus-word boundary into two consecutive bus beats.

---
 rtl/store_align_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/store_align_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | store_align_unit                                                            |
// | Store-path aligner: byte-lane masks and lane-aligned data for an XLEN bus,  |
// | registered behind valid/ready. MISALIGNED_SPLIT_EN enables boundary splits. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module store_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [XLEN-1:0]   st_data,
  input  logic [2:0]        st_func3,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_wmask,
  output logic [XLEN-1:0]   bus_wdata,
  output logic              bus_last,
  output logic              st_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]          size;
  logic [OFF_W-1:0]    off;
  logic                illegal;
  logic                misaligned;
  logic                split;
  logic                legal;
  logic [NB-1:0]       m1;
  logic [XLEN-1:0]     dmask;
  logic [2*NB-1:0]     m2;
  logic [2*XLEN-1:0]   d2;
  logic [ADDR_W-1:0]   base;
  logic                accept;
  logic                take;
  logic                drop;

  logic                split_q;
  logic [ADDR_W-1:0]   b1_addr;
  logic [NB-1:0]       b1_mask;
  logic [XLEN-1:0]     b1_data;

  assign size    = 4'd1 << st_func3[1:0];
  assign off     = st_addr[OFF_W-1:0];
  assign illegal = st_func3[2] | (5'(size) > 5'(NB));
  assign base    = {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MISALIGNED_SPLIT_EN
  assign misaligned = 1'b0;
  assign split      = (5'(off) + 5'(size)) > 5'(NB);
`else
  // Naturally aligned stores can never cross a bus word, so beat 1 is dead.
  assign misaligned = |(off & OFF_W'(size - 4'd1));
  assign split      = 1'b0;
`endif

  assign legal = !illegal && !misaligned;

  always_comb begin
    m1    = '0;
    dmask = '0;
    for (int i = 0; i < NB; i++) begin
      m1[i]           = (i < int'(size));
      dmask[8*i +: 8] = {8{m1[i]}};
    end
  end

  // Double-width shift: low half is beat 0, high half spills into beat 1.
  assign m2 = {{NB{1'b0}}, m1} << off;
  assign d2 = {{XLEN{1'b0}}, st_data & dmask} << {off, 3'b000};

  assign st_ready = (state == IDLE) || ((state == BEAT0) && !split_q && bus_ready);
  assign accept   = st_valid && st_ready;
  assign take     = accept && legal;
  assign drop     = accept && !legal;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take) state_next = BEAT0;
      end
      BEAT0: begin
        if (bus_ready) begin
          if (split_q)   state_next = BEAT1;
          else if (take) state_next = BEAT0;
          else           state_next = IDLE;
        end
      end
      BEAT1: begin
        if (bus_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wmask <= '0;
      bus_wdata <= '0;
      bus_last  <= 1'b0;
      st_err    <= 1'b0;
      split_q   <= 1'b0;
      b1_addr   <= '0;
      b1_mask   <= '0;
      b1_data   <= '0;
    end else begin
      bus_valid <= (state_next != IDLE);
      st_err    <= drop;
      if (take) begin
        bus_addr  <= base;
        bus_wmask <= m2[NB-1:0];
        bus_wdata <= d2[XLEN-1:0];
        bus_last  <= !split;
        split_q   <= split;
        b1_addr   <= base + ADDR_W'(NB);
        b1_mask   <= m2[2*NB-1:NB];
        b1_data   <= d2[2*XLEN-1:XLEN];
      end else if ((state == BEAT0) && bus_ready && split_q) begin
        bus_addr  <= b1_addr;
        bus_wmask <= b1_mask;
        bus_wdata <= b1_data;
        bus_last  <= 1'b1;
        split_q   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
